// File: rtl/reaction_timer_if.sv
// -----------------------------------------------------------------------------
// reaction_timer_if
// Groups the reaction-timer controller's button pulses and its status/result
// outputs into one bundle.
//   master : drives start/stop/clear, observes the status and result outputs
//   slave  : the controller; receives the pulses, drives the outputs
// Signals:
//   start, stop, clear : single-cycle debounced pulses
//   stim_led           : stimulus LED (MEASURE only)
//   busy               : trial in progress (WAIT or MEASURE)
//   delay_units[4:0]   : delay drawn at the last start
//   result_ms[13:0]    : latched reaction time in ms
//   result_valid       : result available (DONE)
//   early              : press arrived before the stimulus (EARLY)
//   timeout            : DONE reached by saturation, not by a press
// -----------------------------------------------------------------------------
interface reaction_timer_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        stim_led;
  logic        busy;
  logic [4:0]  delay_units;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        early;
  logic        timeout;

  modport master (
    output start, stop, clear,
    input  stim_led, busy, delay_units, result_ms, result_valid, early, timeout
  );

  modport slave (
    input  start, stop, clear,
    output stim_led, busy, delay_units, result_ms, result_valid, early, timeout
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_timer_ctrl
// Sequences one reaction-timer trial: on start it draws a 4-bit random value
// from a free-running LFSR, waits (rand + MIN_UNITS) delay units, lights the
// stimulus LED and counts whole milliseconds until the reaction press.
// Presses before the stimulus end in EARLY; a count that saturates at MAX_MS
// without a press ends in DONE with timeout set.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : reaction_timer_if.slave (pulses in, status/result out)
// -----------------------------------------------------------------------------
module reaction_timer_ctrl #(
  parameter int unsigned TICK_DIV   = 100000,   // clk cycles per 1 ms tick
  parameter int unsigned UNIT_TICKS = 250,      // ms ticks per delay unit
  parameter int unsigned MIN_UNITS  = 4,        // added to the random value
  parameter int unsigned MAX_MS     = 9999,     // saturation / timeout count
  parameter logic [15:0] LFSR_SEED  = 16'hACE1  // must be non-zero
) (
  input logic             clk,
  input logic             reset_n,
  reaction_timer_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int UNIT_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_TICKS - 1);
  localparam logic [13:0]       MS_MAX    = 14'(MAX_MS);
  localparam logic [4:0]        MIN_U     = 5'(MIN_UNITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MEASURE,
    S_DONE,
    S_EARLY
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [15:0]       r_lfsr;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [UNIT_W-1:0] r_unit_cnt;
  logic [4:0]        r_delay_cnt;
  logic [13:0]       r_ms_cnt;
  logic [4:0]        r_delay_units;
  logic [13:0]       r_result_ms;
  logic              r_timeout;

  // ---------------------------------------------------------------------------
  // Combinational next values
  // ---------------------------------------------------------------------------
  state_t            w_state_next;
  logic              w_tick;
  logic              w_lfsr_fb;
  logic [4:0]        w_delay_load;
  logic [UNIT_W-1:0] w_unit_next;
  logic [4:0]        w_delay_cnt_next;
  logic [13:0]       w_ms_next;
  logic [4:0]        w_delay_units_next;
  logic [13:0]       w_result_next;
  logic              w_timeout_next;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10). It runs in every
  // state so the drawn value depends on when the user presses start.
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_delay_load = 5'(r_lfsr[3:0]) + MIN_U;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update from the same pre-edge values, regardless of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath decisions
  // clear has top priority; within a state, stop beats tick/expiry events.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets its default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next       = r_state;
    w_unit_next        = r_unit_cnt;
    w_delay_cnt_next   = r_delay_cnt;
    w_ms_next          = r_ms_cnt;
    w_delay_units_next = r_delay_units;
    w_result_next      = r_result_ms;
    w_timeout_next     = r_timeout;

    if (bus.clear) begin
      // Abort/acknowledge: results and the drawn delay stay visible.
      w_state_next   = S_IDLE;
      w_timeout_next = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_delay_cnt_next   = w_delay_load;
            w_delay_units_next = w_delay_load;
            w_unit_next        = '0;
            w_ms_next          = '0;
            w_timeout_next     = 1'b0;
            w_state_next       = S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.stop) begin
            w_state_next = S_EARLY;
          end else if (w_tick) begin
            if (r_unit_cnt == UNIT_LAST) begin
              w_unit_next      = '0;
              w_delay_cnt_next = r_delay_cnt - 5'd1;
              // Last unit elapsed: stimulus goes on from the next cycle.
              if (r_delay_cnt == 5'd1) begin
                w_state_next = S_MEASURE;
              end
            end else begin
              w_unit_next = r_unit_cnt + UNIT_W'(1);
            end
          end
        end

        S_MEASURE: begin
          if (bus.stop) begin
            w_result_next  = r_ms_cnt;
            w_timeout_next = 1'b0;
            w_state_next   = S_DONE;
          end else if (w_tick) begin
            if (r_ms_cnt >= MS_MAX) begin
              w_result_next  = MS_MAX;
              w_timeout_next = 1'b1;
              w_state_next   = S_DONE;
            end else begin
              w_ms_next = r_ms_cnt + 14'd1;
            end
          end
        end

        S_DONE, S_EARLY: begin
          // Hold everything until clear.
        end

        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr        <= LFSR_SEED;
      r_tick_cnt    <= '0;
      r_unit_cnt    <= '0;
      r_delay_cnt   <= '0;
      r_ms_cnt      <= '0;
      r_delay_units <= '0;
      r_result_ms   <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

      // Restart the ms prescaler on every state change so the first tick in
      // a state lands exactly TICK_DIV cycles after entry.
      if (w_state_next != r_state) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end

      r_unit_cnt    <= w_unit_next;
      r_delay_cnt   <= w_delay_cnt_next;
      r_ms_cnt      <= w_ms_next;
      r_delay_units <= w_delay_units_next;
      r_result_ms   <= w_result_next;
      r_timeout     <= w_timeout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: status flags decode straight from the state register, so they
  // follow an asynchronous reset without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  assign bus.stim_led     = (r_state == S_MEASURE);
  assign bus.busy         = (r_state == S_WAIT) || (r_state == S_MEASURE);
  assign bus.result_valid = (r_state == S_DONE);
  assign bus.early        = (r_state == S_EARLY);
  assign bus.timeout      = (r_state == S_DONE) && r_timeout;
  assign bus.delay_units  = r_delay_units;
  assign bus.result_ms    = r_result_ms;

endmodule
